// File: rtl/nn_param_loader.sv
// Stream loader: unpacks 64-bit words into sample, hidden and final weight stores.
// Ports: clk/rst_n, start/load_sel, s_valid/s_ready/s_data, busy/data_ok/wts_ok, rd_* port; NN_LOADER_ERR_EN adds s_last/err.
module nn_param_loader #(
  parameter int DW     = 64,
  parameter int ROWS   = 100,
  parameter int COLS   = 15,
  parameter int LAYERS = 10,
  parameter int OUTS   = 2,
  localparam int RMAX  = (ROWS > LAYERS)
                         ? ((ROWS > OUTS) ? ROWS : OUTS)
                         : ((LAYERS > OUTS) ? LAYERS : OUTS),
  localparam int CMAX  = ((COLS > LAYERS) ? COLS : LAYERS) + 1,
  localparam int RW    = $clog2(RMAX),
  localparam int CW    = $clog2(CMAX)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          load_sel,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_data,
`ifdef NN_LOADER_ERR_EN
  input  logic          s_last,
  output logic          err,
`endif
  output logic          busy,
  output logic          data_ok,
  output logic          wts_ok,
  input  logic [1:0]    rd_region,
  input  logic [RW-1:0] rd_row,
  input  logic [CW-1:0] rd_col,
  output logic [DW-1:0] rd_data
);

  localparam int SN  = ROWS * (COLS + 1);
  localparam int HN  = LAYERS * (COLS + 1);
  localparam int FN  = OUTS * (LAYERS + 1);
  localparam int SAW = $clog2(SN);
  localparam int HAW = $clog2(HN);
  localparam int FAW = $clog2(FN);

  typedef enum logic [1:0] {
    IDLE, LD_SMP, LD_HID, LD_FIN
  } state_t;

  state_t        state_q, state_d;
  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  logic          dok_d, wok_d;
  logic          acc, at_end, row_end, bad;
  logic [RW-1:0] last_row;
  logic [CW-1:0] last_col;

  logic [DW-1:0] smp_mem [SN];
  logic [DW-1:0] hid_mem [HN];
  logic [DW-1:0] fin_mem [FN];

  assign s_ready = (state_q != IDLE);
  assign busy    = s_ready;
  assign acc     = s_valid & s_ready;

  always_comb begin
    last_row = RW'(ROWS - 1);
    last_col = CW'(COLS);
    unique case (1'b1)
      state_q == LD_HID: last_row = RW'(LAYERS - 1);
      state_q == LD_FIN: begin
        last_row = RW'(OUTS - 1);
        last_col = CW'(LAYERS);
      end
      default: ;
    endcase
  end

  assign row_end = (col_q == last_col);
  assign at_end  = row_end && (row_q == last_row);

`ifdef NN_LOADER_ERR_EN
  logic err_d;
  // The hidden region end is not the end of the weight load.
  assign bad = s_last != (at_end && state_q != LD_HID);
`else
  assign bad = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    dok_d   = data_ok;
    wok_d   = wts_ok;
`ifdef NN_LOADER_ERR_EN
    err_d   = err;
`endif
    if (state_q == IDLE) begin
      if (start) begin
        row_d = '0;
        col_d = '0;
`ifdef NN_LOADER_ERR_EN
        err_d = 1'b0;
`endif
        if (load_sel) begin
          state_d = LD_HID;
          wok_d   = 1'b0;
        end else begin
          state_d = LD_SMP;
          dok_d   = 1'b0;
        end
      end
    end else if (acc) begin
      if (bad) begin
        state_d = IDLE;
        row_d   = '0;
        col_d   = '0;
`ifdef NN_LOADER_ERR_EN
        err_d   = 1'b1;
`endif
      end else if (at_end) begin
        row_d = '0;
        col_d = '0;
        unique case (state_q)
          LD_SMP: begin
            state_d = IDLE;
            dok_d   = 1'b1;
          end
          LD_HID: state_d = LD_FIN;
          default: begin
            state_d = IDLE;
            wok_d   = 1'b1;
          end
        endcase
      end else if (row_end) begin
        col_d = '0;
        row_d = row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      row_q   <= '0;
      col_q   <= '0;
      data_ok <= 1'b0;
      wts_ok  <= 1'b0;
`ifdef NN_LOADER_ERR_EN
      err     <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      data_ok <= dok_d;
      wts_ok  <= wok_d;
`ifdef NN_LOADER_ERR_EN
      err     <= err_d;
`endif
    end
  end

  logic [SAW-1:0] s_wa, s_ra;
  logic [HAW-1:0] h_wa, h_ra;
  logic [FAW-1:0] f_wa, f_ra;
  logic           s_ok, h_ok, f_ok;

  assign s_wa = SAW'(int'(row_q) * (COLS + 1) + int'(col_q));
  assign h_wa = HAW'(int'(row_q) * (COLS + 1) + int'(col_q));
  assign f_wa = FAW'(int'(row_q) * (LAYERS + 1) + int'(col_q));
  assign s_ra = SAW'(int'(rd_row) * (COLS + 1) + int'(rd_col));
  assign h_ra = HAW'(int'(rd_row) * (COLS + 1) + int'(rd_col));
  assign f_ra = FAW'(int'(rd_row) * (LAYERS + 1) + int'(rd_col));

  assign s_ok = int'(rd_row) < ROWS && int'(rd_col) <= COLS;
  assign h_ok = int'(rd_row) < LAYERS && int'(rd_col) <= COLS;
  assign f_ok = int'(rd_row) < OUTS && int'(rd_col) <= LAYERS;

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (acc) begin
      unique case (state_q)
        LD_SMP:  smp_mem[s_wa] <= s_data;
        LD_HID:  hid_mem[h_wa] <= s_data;
        default: fin_mem[f_wa] <= s_data;
      endcase
    end
  end

  // Nonblocking read yields the old word on a same-cycle write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else begin
      unique case (rd_region)
        2'd0:    rd_data <= s_ok ? smp_mem[s_ra] : '0;
        2'd1:    rd_data <= h_ok ? hid_mem[h_ra] : '0;
        2'd2:    rd_data <= f_ok ? fin_mem[f_ra] : '0;
        default: rd_data <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_nn_param_loader.sv
// Directed/randomized bench for nn_param_loader.
// Checks flags, handshake and read port against a flat reference store.
module tb_nn_param_loader;
  localparam int ROWS = 100, COLS = 15, LAYERS = 10, OUTS = 2;
  localparam int NS = ROWS * (COLS + 1);
  localparam int NH = LAYERS * (COLS + 1);
  localparam int NF = OUTS * (LAYERS + 1);
  localparam int NW = NH + NF;

  logic        clk = 0, rst_n = 0;
  logic        start = 0, load_sel = 0;
  logic        s_valid = 0, s_ready;
  logic [63:0] s_data = '0;
  logic        busy, data_ok, wts_ok;
  logic [1:0]  rd_region = 2'd3;
  logic [6:0]  rd_row = '0;
  logic [3:0]  rd_col = '0;
  logic [63:0] rd_data;
`ifdef NN_LOADER_ERR_EN
  logic        s_last = 0, err;
`endif

  nn_param_loader dut (
    .clk(clk), .rst_n(rst_n),
    .start(start), .load_sel(load_sel),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
`ifdef NN_LOADER_ERR_EN
    .s_last(s_last), .err(err),
`endif
    .busy(busy), .data_ok(data_ok), .wts_ok(wts_ok),
    .rd_region(rd_region), .rd_row(rd_row), .rd_col(rd_col),
    .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  int nvec = 0, nerr = 0;
  logic [63:0] m_smp [NS];
  logic [63:0] m_wts [NW];
  bit m_dok = 0, m_wok = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference view: a load is a flat row-major word list per region.
  function automatic logic [63:0] model_rd(int rg, int r, int c);
    case (rg)
      0: return (r < ROWS && c <= COLS) ? m_smp[r*(COLS+1)+c] : 64'd0;
      1: return (r < LAYERS && c <= COLS) ? m_wts[r*(COLS+1)+c] : 64'd0;
      2: return (r < OUTS && c <= LAYERS)
                ? m_wts[NH + r*(LAYERS+1) + c] : 64'd0;
      default: return 64'd0;
    endcase
  endfunction

  task automatic rd(input int rg, input int r, input int c);
    rd_region = 2'(rg);
    rd_row = 7'(r);
    rd_col = 4'(c);
    @(posedge clk); #1;
    chk($sformatf("rd(%0d,%0d,%0d)", rg, r, c), rd_data, model_rd(rg, r, c));
  endtask

  task automatic go(input bit sel);
    start = 1; load_sel = sel;
    @(posedge clk); #1;
    start = 0;
    chk("busy_on_start", busy, 1);
  endtask

  task automatic push(input logic [63:0] d, input bit last, input int gap);
    s_data = d; s_valid = 1;
`ifdef NN_LOADER_ERR_EN
    s_last = last;
`endif
    chk("s_ready", s_ready, 1);
    @(posedge clk); #1;
    s_valid = 0;
`ifdef NN_LOADER_ERR_EN
    s_last = 0;
`endif
    if (last && gap < 0) $display("note: negative gap");
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic flags(input string tag);
    chk({tag, ".data_ok"}, data_ok, m_dok);
    chk({tag, ".wts_ok"}, wts_ok, m_wok);
  endtask

  initial begin
    logic [63:0] d;
    // 1: reset
    #3;
    chk("rst.s_ready", s_ready, 0);
    chk("rst.busy", busy, 0);
    chk("rst.rd_data", rd_data, 0);
    flags("rst");
    @(posedge clk); #1 rst_n = 1;
    @(posedge clk); #1;

    // 2: sample load, s_data = k, valid held high
    go(0);
    m_dok = 0;
    for (int k = 0; k < NS; k++) begin
      m_smp[k] = 64'(k);
      push(64'(k), k == NS-1, 0);
      if (k == NS-2) chk("smp.ok_early", data_ok, 0);
    end
    m_dok = 1;
    flags("smp_done");
    chk("smp.busy", busy, 0);
    rd(0, 0, 15);
    chk("rd0_0_15_lit", rd_data, 64'd15);
    rd(0, 99, 15);
    chk("rd0_99_15_lit", rd_data, 64'd1599);
    for (int i = 0; i < 6; i++)
      rd(0, $urandom_range(0, ROWS-1), $urandom_range(0, COLS));

    // 3: weight load with valid toggling
    go(1);
    for (int k = 0; k < NW; k++) begin
      m_wts[k] = 64'(k);
      push(64'(k), k == NW-1, 1);
      if (k == NH) chk("wts.busy_mid", busy, 1);
    end
    m_wok = 1;
    flags("wts_done");
    rd(1, 9, 15);
    chk("rd1_9_15_lit", rd_data, 64'd159);
    rd(2, 1, 10);
    chk("rd2_1_10_lit", rd_data, 64'd181);
    for (int i = 0; i < 4; i++)
      rd(2, $urandom_range(0, OUTS-1), $urandom_range(0, LAYERS));

    // 4: reset mid-load
    go(0);
    m_dok = 0;
    for (int k = 0; k < 500; k++) begin
      d = {$urandom, $urandom};
      m_smp[k] = d;
      push(d, 0, 0);
    end
    rd_region = 2'd0;
    rst_n = 0; #1;
    m_dok = 0; m_wok = 0;
    chk("midrst.busy", busy, 0);
    chk("midrst.s_ready", s_ready, 0);
    chk("midrst.rd_data", rd_data, 0);
    flags("midrst");
    @(posedge clk); #1 rst_n = 1;
    rd(1, 9, 15);
    rd(0, 31, 3);

    // 5: reload with random data/gaps and a stray start
    go(0);
    for (int k = 0; k < NS; k++) begin
      d = {$urandom, $urandom};
      m_smp[k] = d;
      push(d, k == NS-1, ($urandom_range(0, 3) == 0) ? 1 : 0);
      if (k == 0) rd(0, 0, 0);
      if (k == 700) begin
        start = 1; load_sel = 1;
        @(posedge clk); #1;
        start = 0; load_sel = 0;
        chk("stray.busy", busy, 1);
      end
      if (k == NS-2) chk("reload.ok_early", data_ok, 0);
    end
    m_dok = 1;
    flags("reload");
    chk("reload.busy", busy, 0);
    for (int i = 0; i < 6; i++)
      rd(0, $urandom_range(0, ROWS-1), $urandom_range(0, COLS));
    rd(0, 100, 0);
    rd(3, 1, 1);
    rd(1, 10, 0);
    rd(2, 0, 11);
    rd(2, 2, 0);

`ifdef NN_LOADER_ERR_EN
    // 6: framing error then clean load
    go(1);
    for (int k = 0; k <= 100; k++) push(64'(k), k == 100, 0);
    chk("err.set", err, 1);
    chk("err.busy", busy, 0);
    flags("err");
    go(1);
    chk("err.clear", err, 0);
    for (int k = 0; k < NW; k++) begin
      d = {$urandom, $urandom};
      m_wts[k] = d;
      push(d, k == NW-1, 0);
    end
    m_wok = 1;
    chk("err.clean", err, 0);
    flags("clean");
    rd(1, 5, 7);
    rd(2, 1, 4);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
